snail_scan_ctrl: RTL

SNAIL_SCAN_CTRL -- requirements
Module: snail_scan_ctrl

---
 rtl/snail_pkg.sv | 16 +
 rtl/snail_det.sv | 27 ++
 rtl/snail_scan_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/snail_pkg.sv
// Shared types and constants for the snail scan controller.
// Holds FSM state type, detector state codes and default word width.
package snail_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic SAD   = 1'b0;
  localparam logic WAIT1 = 1'b1;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/snail_det.sv
// "11" detector: Mealy hit = WAIT1 & D, state tracks last bit.
// Ports: clk, _rst, clr (sync to SAD), en (advance), D, hit.
module snail_det
  import snail_pkg::*;
(
  input  logic clk,
  input  logic _rst,
  input  logic clr,
  input  logic en,
  input  logic D,
  output logic hit
);

  logic st;

  assign hit = (st == WAIT1) & D;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst)
      st <= SAD;
    else if (clr)
      st <= SAD;
    else if (en)
      st <= D ? WAIT1 : SAD;
  end

endmodule

// File: rtl/snail_scan_ctrl.sv
// Serially scans WIDTH-bit words MSB first and counts "11" hits.
// Ports: clk, _rst, in_valid/in_ready/in_data, abort,
//        out_valid, out_count, busy. Option: SNAIL_CARRY_EN.
module snail_scan_ctrl
  import snail_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             out_valid,
  output logic [CW-1:0]    out_count,
  output logic             busy
);

  state_t state, state_n;

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    hit_cnt;
  logic [CW-1:0]    out_q;

  logic accept;
  logic det_en;
  logic det_clr;
  logic hit;
  logic last;

  assign last = (bit_cnt == CW'(WIDTH - 1));
  assign busy = (state != IDLE);

  snail_det u_det (
    .clk (clk),
    ._rst(_rst),
    .clr (det_clr),
    .en  (det_en),
    .D   (sreg[WIDTH-1]),
    .hit (hit)
  );

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    det_en    = 1'b0;
    det_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (abort) begin
          det_clr = 1'b1;
        end else if (in_valid) begin
          accept  = 1'b1;
          state_n = SHIFT;
`ifdef SNAIL_CARRY_EN
          det_clr = 1'b0;
`else
          det_clr = 1'b1;
`endif
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n = IDLE;
          det_clr = 1'b1;
        end else begin
          det_en = 1'b1;
          if (last)
            state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        if (abort)
          det_clr = 1'b1;
        else
          out_valid = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // out_q keeps the last delivered count; DONE shows the live one.
  assign out_count = out_valid ? hit_cnt : out_q;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      hit_cnt <= '0;
      out_q   <= '0;
    end else begin
      if (accept) begin
        sreg    <= in_data;
        bit_cnt <= '0;
        hit_cnt <= '0;
      end else if (state == SHIFT) begin
        if (abort) begin
          hit_cnt <= '0;
        end else begin
          sreg    <= sreg << 1;
          bit_cnt <= bit_cnt + CW'(1);
          if (hit)
            hit_cnt <= hit_cnt + CW'(1);
        end
      end else if (state == DONE && abort) begin
        hit_cnt <= '0;
      end
      if (out_valid)
        out_q <= hit_cnt;
    end
  end

endmodule
